button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//   Front end for the four raw paddle push-buttons (p1 up/down, p2 up/down).
//   Synchronises, debounces and edge-detects each button, then produces
//   single-cycle move commands with auto-repeat while a button is held.
//   Sits directly upstream of board_controller, which moves a paddle one
//   step per move pulse. Opposite buttons of the same player cancel.
// PARAMETERS
//   DEB_CNT      250000    stable cycles required to accept a level change (5 ms @ 50 MHz)
//   REPEAT_DLY   12500000  cycles from press pulse to first repeat pulse (250 ms)
//   REPEAT_RATE  2500000   cycles between subsequent repeat pulses (50 ms)
//   CNT_W        24        counter width; must hold max(DEB_CNT, REPEAT_DLY, REPEAT_RATE)
// PORTS
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-low reset
//   btn_raw    in   4  raw buttons, active-low (0 = pressed); [0]=p1u [1]=p1d [2]=p2u [3]=p2d
//   btn_level  out  4  debounced level, active-high (1 = pressed)
//   btn_press  out  4  1-cycle pulse on each debounced press edge
//   btn_move   out  4  1-cycle move pulse: press pulse plus auto-repeats, after conflict masking
// BEHAVIOUR
//   Reset (async, reset=0):
//   - Sync flops = 1 (released). btn_level = 0, btn_press = 0, btn_move = 0.
//   - All counters = 0, all repeat FSMs = IDLE.
//   Per channel, fully independent:
//   - Synchroniser: 2-flop sync of btn_raw, then inverted to active-high (sync2).
//   - Debounce: counter increments on each edge where sync2 != btn_level.
//     Counter clears on any edge where they are equal (bounce restarts the count).
//     On the edge where counter == DEB_CNT-1 and sync2 != btn_level, btn_level toggles
//     and the counter clears.
//   - Latency: btn_raw change set up before edge 1 -> btn_level changes on edge DEB_CNT+2.
//   - btn_press is registered high on the same edge btn_level goes 0->1, for exactly 1 cycle.
//     Release edges produce no pulse.
//   Repeat FSM (per channel), states IDLE / WAIT / RPT; rcnt is the repeat counter:
//   - IDLE: on the press edge -> WAIT, rcnt = 0.
//   - WAIT: rcnt++. When rcnt == REPEAT_DLY-1 -> RPT, rcnt = 0, repeat pulse.
//   - RPT: rcnt++. When rcnt == REPEAT_RATE-1 -> rcnt = 0, repeat pulse.
//   - WAIT or RPT with btn_level == 0 -> IDLE immediately; no pulse on that edge.
//   - Repeat pulses are registered, 1 cycle wide, never coincident with btn_press.
//   Move output and conflict masking:
//   - raw_move = btn_press | repeat pulse.
//   - btn_move[i] = raw_move[i] & ~btn_level[partner]; partner pairs are 0<->1 and 2<->3.
//   - Both buttons of a pair held -> no move pulses on either channel.
//     Their FSMs keep running, so pulses resume on the correct cadence when one is released.
//   - btn_press is not masked.
//   Boundaries:
//   - A button held through reset deassertion is seen as a new press
//     (level rises on edge DEB_CNT+2).
//   - Reset asserted mid-count discards all partial counts.
//   - Counters never wrap, since they are always cleared at their terminal value.
//   - All outputs are registered; no combinational path from btn_raw to any output.
// TESTING  (bench parameters: DEB_CNT=4, REPEAT_DLY=10, REPEAT_RATE=3)
//   1. btn_raw[0]=0 before edge 1, then held 5 cycles
//      -> btn_level[0]=1 and btn_press[0]=btn_move[0]=1 on edge 6 only.
//   2. btn_raw[2] bounces 0,1,0,1 with 2-cycle segments, then stays 1
//      -> btn_level[2] stays 0; no pulses on any output.
//   3. btn_raw[1] held 0 for 30 cycles
//      -> move pulses at edges 6, 16, 19, 22, 25, 28 (press edge + 10, then every 3).
//   4. btn_raw[0] and btn_raw[1] both held
//      -> btn_press fires on both; btn_move[1:0] stays 0.
//      Release [1] -> [0] resumes repeats on its existing cadence.
//   5. Hold btn_raw[3] for 12 cycles, assert reset for 1 cycle, release reset while still held
//      -> all outputs 0 during reset; btn_press[3] fires again 6 edges after reset release.
//   6. Release a held button in RPT -> btn_level falls 6 edges later; no further btn_move pulses.

Source files
------------

// File: rtl/button_conditioner_if.sv
//------------------------------------------------------------------------------
// Module   : button_conditioner_if
// Brief    : Raw paddle buttons in, conditioned level/press/move vectors out.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface button_conditioner_if;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_move;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_move
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_move
  );
endinterface

`default_nettype wire

// File: rtl/button_conditioner.sv
//------------------------------------------------------------------------------
// Module   : button_conditioner
// Brief    : Sync, debounce, press-detect and auto-repeat for four paddle buttons.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
  parameter int DEB_CNT     = 250000,
  parameter int REPEAT_DLY  = 12500000,
  parameter int REPEAT_RATE = 2500000,
  parameter int CNT_W       = 24
) (
  input wire clk,
  input wire reset,
  button_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] btn_on;
  logic [3:0] level_q;
  logic [3:0] level_d;
  logic [3:0] press_q;
  logic [3:0] move_q;

  // Sync flops hold the raw (active-low) polarity, so reset means released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign btn_on = ~sync2_q;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_ch
      localparam int PARTNER = i ^ 1;

      logic [CNT_W-1:0] dcnt_q;
      logic [CNT_W-1:0] dcnt_d;
      logic [CNT_W-1:0] rcnt_q;
      logic [CNT_W-1:0] rcnt_d;
      rpt_state_e       state_q;
      rpt_state_e       state_d;
      logic             lvl_q;
      logic             lvl_d;
      logic             prs_q;
      logic             prs_d;
      logic             rpt_d;
      logic             mov_q;
      logic             mov_d;

      always_comb begin
        dcnt_d = '0;
        lvl_d  = lvl_q;
        prs_d  = 1'b0;
        if (btn_on[i] != lvl_q) begin
          if (dcnt_q == DEB_LAST) begin
            lvl_d = ~lvl_q;
            prs_d = ~lvl_q;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end

      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpt_d   = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (prs_d) begin
              state_d = ST_WAIT;
              rcnt_d  = '0;
            end
          end
          ST_WAIT: begin
            if (!lvl_q) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == DLY_LAST) begin
              state_d = ST_RPT;
              rcnt_d  = '0;
              rpt_d   = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          ST_RPT: begin
            if (!lvl_q) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == RATE_LAST) begin
              rcnt_d = '0;
              rpt_d  = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end

      // Mask against the partner's next level so a simultaneous press of both cancels.
      assign mov_d = (prs_d | rpt_d) & ~level_d[PARTNER];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dcnt_q  <= '0;
          rcnt_q  <= '0;
          state_q <= ST_IDLE;
          lvl_q   <= 1'b0;
          prs_q   <= 1'b0;
          mov_q   <= 1'b0;
        end else begin
          dcnt_q  <= dcnt_d;
          rcnt_q  <= rcnt_d;
          state_q <= state_d;
          lvl_q   <= lvl_d;
          prs_q   <= prs_d;
          mov_q   <= mov_d;
        end
      end

      assign level_d[i] = lvl_d;
      assign level_q[i] = lvl_q;
      assign press_q[i] = prs_q;
      assign move_q[i]  = mov_q;
    end
  endgenerate

  assign bus.btn_level = level_q;
  assign bus.btn_press = press_q;
  assign bus.btn_move  = move_q;

endmodule

`default_nettype wire
